// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives an 8N1 UART instruction image and writes 14-bit words into
// program RAM. The core is held in reset until a complete image with a valid checksum is written.
//
//  RX state  | meaning
//  ----------+---------------------------------------------------------------
//  RX_IDLE   | line idle, waiting for a falling edge on the synchronised rx
//  RX_START  | half-bit wait, then re-check the start bit (high = false start)
//  RX_DATA   | sampling 8 data bits LSB first, one bit period apart
//  RX_STOP   | sampling the stop bit: high = byte strobe, low = framing error
//
//  LD state  | meaning
//  ----------+---------------------------------------------------------------
//  LD_SYNC   | hunting for the header byte, other bytes dropped
//  LD_CNT_LO | expecting low byte of the word count
//  LD_CNT_HI | expecting high byte of the word count (bits 7:3 must be 0)
//  LD_DAT_LO | expecting low byte of the next instruction
//  LD_DAT_HI | expecting high byte (bits 7:6 must be 0), issues the RAM write
//  LD_CHK    | expecting checksum byte
//  LD_DONE   | image accepted, core released, rx ignored until rst
//  LD_ERR    | image rejected, core held, rx ignored until rst
module uart_prog_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        prog_we,
    output logic [10:0] prog_addr,
    output logic [13:0] prog_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_SYNC,
        LD_CNT_LO,
        LD_CNT_HI,
        LD_DAT_LO,
        LD_DAT_HI,
        LD_CHK,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    // synchroniser and edge-detect flops
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic rx_prev_q, rx_prev_d;

    // receiver
    rx_state_t     rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_tc;

    // loader
    ld_state_t   ld_state_q, ld_state_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  lo_q, lo_d;
    logic [10:0] words_left_q, words_left_d;
    logic        prog_we_q, prog_we_d;
    logic [10:0] prog_addr_q, prog_addr_d;
    logic [13:0] prog_wdata_q, prog_wdata_d;
    logic [10:0] count_w;

    // two-flop synchroniser on the asynchronous rx pin, plus one delay for edge detection
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
    end

    // synchroniser registers; the line idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    // receiver next-state: bit timer counts down and every sample happens at terminal count
    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_tc      = (rx_timer_q == '0);
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_timer_d = TIMER_HALF;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_timer_d = TIMER_FULL;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_timer_d = rx_timer_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_timer_d = TIMER_FULL;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_timer_d = rx_timer_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    // back to idle at the sample point so a following start bit is not missed
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end else begin
                    rx_timer_d = rx_timer_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // receiver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign count_w = {rx_shift_q[2:0], lo_q};

    // loader next-state: frame parsing, checksum accumulation and RAM write generation
    always_comb begin
        ld_state_d   = ld_state_q;
        sum_d        = sum_q;
        lo_d         = lo_q;
        words_left_d = words_left_q;
        prog_we_d    = 1'b0;
        prog_wdata_d = prog_wdata_q;
        // address steps the cycle after each write pulse
        prog_addr_d  = prog_we_q ? prog_addr_q + 11'd1 : prog_addr_q;
        if (ld_state_q == LD_DONE || ld_state_q == LD_ERR) begin
            ld_state_d = ld_state_q;
        end else if (rx_ferr_q) begin
            ld_state_d = LD_ERR;
        end else if (rx_valid_q) begin
            case (ld_state_q)
                LD_SYNC: begin
                    if (rx_shift_q == SYNC_BYTE) begin
                        ld_state_d = LD_CNT_LO;
                        sum_d      = 8'd0;
                    end
                end
                LD_CNT_LO: begin
                    lo_d       = rx_shift_q;
                    sum_d      = sum_q + rx_shift_q;
                    ld_state_d = LD_CNT_HI;
                end
                LD_CNT_HI: begin
                    sum_d = sum_q + rx_shift_q;
                    if (rx_shift_q[7:3] != 5'd0) begin
                        ld_state_d = LD_ERR;
                    end else begin
                        words_left_d = count_w;
                        ld_state_d   = (count_w == 11'd0) ? LD_CHK : LD_DAT_LO;
                    end
                end
                LD_DAT_LO: begin
                    lo_d       = rx_shift_q;
                    sum_d      = sum_q + rx_shift_q;
                    ld_state_d = LD_DAT_HI;
                end
                LD_DAT_HI: begin
                    if (rx_shift_q[7:6] != 2'd0) begin
                        ld_state_d = LD_ERR;
                    end else begin
                        sum_d        = sum_q + rx_shift_q;
                        prog_we_d    = 1'b1;
                        prog_wdata_d = {rx_shift_q[5:0], lo_q};
                        words_left_d = words_left_q - 11'd1;
                        ld_state_d   = (words_left_q == 11'd1) ? LD_CHK : LD_DAT_LO;
                    end
                end
                LD_CHK: begin
                    ld_state_d = (rx_shift_q == sum_q) ? LD_DONE : LD_ERR;
                end
                default: ld_state_d = LD_ERR;
            endcase
        end
    end

    // loader registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q   <= LD_SYNC;
            sum_q        <= 8'd0;
            lo_q         <= 8'd0;
            words_left_q <= 11'd0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= 11'd0;
            prog_wdata_q <= 14'd0;
        end else begin
            ld_state_q   <= ld_state_d;
            sum_q        <= sum_d;
            lo_q         <= lo_d;
            words_left_q <= words_left_d;
            prog_we_q    <= prog_we_d;
            prog_addr_q  <= prog_addr_d;
            prog_wdata_q <= prog_wdata_d;
        end
    end

    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_wdata = prog_wdata_q;
    assign done       = (ld_state_q == LD_DONE);
    assign err        = (ld_state_q == LD_ERR);
    assign cpu_rst    = (ld_state_q != LD_DONE);
    assign busy       = (ld_state_q != LD_SYNC) && (ld_state_q != LD_DONE) && (ld_state_q != LD_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a byte-stream parser model predicts RAM writes and final status.
module tb_uart_prog_loader;

    localparam int CPB = 8;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        prog_we;
    logic [10:0] prog_addr;
    logic [13:0] prog_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    logic [24:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Parse a byte stream the way the frame format describes it; incomplete frames leave both flags clear.
    function automatic void model_run(input bq_t b);
        int         i;
        int         n;
        logic [7:0] clo, chi, lo, hi, sum;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i >= b.size()) return;
        i++;
        if (i + 1 >= b.size()) return;
        clo = b[i];
        chi = b[i+1];
        i += 2;
        sum = clo + chi;
        if (chi[7:3] != 5'd0) begin
            exp_err = 1'b1;
            return;
        end
        n = {chi[2:0], clo};
        for (int k = 0; k < n; k++) begin
            if (i + 1 >= b.size()) return;
            lo = b[i];
            hi = b[i+1];
            i += 2;
            if (hi[7:6] != 2'd0) begin
                exp_err = 1'b1;
                return;
            end
            exp_q.push_back({11'(k), hi[5:0], lo});
            sum = sum + lo + hi;
        end
        if (i >= b.size()) return;
        if (b[i] == sum) exp_done = 1'b1;
        else exp_err = 1'b1;
    endfunction

    // every write must match the head of the expected write list; status invariants every cycle
    always @(negedge clk) begin
        logic [24:0] e;
        if (started) begin
            if (prog_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stray_write actual addr=%0h data=%0h required no write", prog_addr, prog_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(prog_addr), 32'(e[24:14]));
                    check("write_data", 32'(prog_wdata), 32'(e[13:0]));
                end
            end
            check("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
            check("done_err_exclusive", 32'(done & err), 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_bytes(input bq_t b);
        foreach (b[i]) send_byte(b[i], 1'b0);
        repeat (30) @(negedge clk);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bq_t f1, f;
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h55, 8'h30, 8'h8D, 8'h00, 8'h14};

        do_reset();
        started = 1'b1;
        check("rst_prog_we", 32'(prog_we), 32'd0);
        check("rst_prog_addr", 32'(prog_addr), 32'd0);
        check("rst_prog_wdata", 32'(prog_wdata), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // scenario 1: two-word image, model pinned against hand-computed writes
        model_run(f1);
        check("model_w0", 32'(exp_q[0]), 32'({11'd0, 14'h3055}));
        check("model_w1", 32'(exp_q[1]), 32'({11'd1, 14'h008D}));
        check("model_done", 32'(exp_done), 32'd1);
        send_byte(f1[0], 1'b0);
        repeat (4) @(negedge clk);
        check("s1_busy_after_sync", 32'(busy), 32'd1);
        for (int i = 1; i < f1.size(); i++) send_byte(f1[i], 1'b0);
        repeat (30) @(negedge clk);
        end_checks("s1");
        check("s1_final_addr", 32'(prog_addr), 32'd2);
        send_bytes(f1);
        check("s1_ignored_done", 32'(done), 32'd1);

        // scenario 2: junk before the header
        do_reset();
        f = '{8'h00, 8'hFF, 8'h3C};
        foreach (f1[i]) f.push_back(f1[i]);
        model_run(f);
        check("model_s2_count", 32'(exp_q.size()), 32'd2);
        send_bytes(f);
        end_checks("s2");

        // scenario 3: wrong checksum, writes still happen
        do_reset();
        f = f1;
        f[7] = 8'h15;
        model_run(f);
        check("model_s3_err", 32'(exp_err), 32'd1);
        send_bytes(f);
        end_checks("s3");
        send_bytes(f1);
        check("s3_ignored_err", 32'(err), 32'd1);
        check("s3_ignored_cpu_rst", 32'(cpu_rst), 32'd1);

        // scenario 4a: zero-length image
        do_reset();
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        model_run(f);
        send_bytes(f);
        end_checks("s4a");
        check("s4a_done_literal", 32'(done), 32'd1);

        // scenario 4b: count high byte with bit 3 set
        do_reset();
        f = '{8'hA5, 8'h01, 8'h08};
        model_run(f);
        send_bytes(f);
        end_checks("s4b");
        check("s4b_err_literal", 32'(err), 32'd1);

        // scenario 4c: data high byte with bit 6 set, no write
        do_reset();
        f = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h40};
        model_run(f);
        send_bytes(f);
        end_checks("s4c");

        // scenario 5a: framing error on CNT_LO
        do_reset();
        exp_done = 1'b0;
        exp_err  = 1'b1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b1);
        repeat (30) @(negedge clk);
        end_checks("s5a");

        // scenario 5b: short low glitch on an idle line
        do_reset();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("s5b_busy", 32'(busy), 32'd0);
        check("s5b_err", 32'(err), 32'd0);
        model_run(f1);
        send_bytes(f1);
        end_checks("s5b");

        // scenario 6: reset after the first word, then a full resend
        do_reset();
        f = '{8'hA5, 8'h02, 8'h00, 8'h55, 8'h30};
        model_run(f);
        send_bytes(f);
        check("s6_addr_after_w0", 32'(prog_addr), 32'd1);
        check("s6_w0_seen", 32'(exp_q.size()), 32'd0);
        check("s6_busy_mid", 32'(busy), 32'd1);
        do_reset();
        check("s6_rst_addr", 32'(prog_addr), 32'd0);
        check("s6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("s6_rst_busy", 32'(busy), 32'd0);
        model_run(f1);
        send_bytes(f1);
        end_checks("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
